poly_wave_synth: RTL and testbench

- Parametrised, time-multiplexed polyphonic synthesizer. Successor to the fixed 8-voice Synthesizer.
- Adds per-voice phase accumulators, selectable waveform, gate-driven attack/release envelopes, master attenuation and output saturation.
- Sits between Keyboard (supplies phase increments and gates) and the AUDIO_L/AUDIO_R path in emu, on the audio clock domain.

---
 rtl/poly_wave_synth_if.sv | 35 +++
 rtl/poly_wave_synth.sv | 149 ++++++++++++++
 tb/tb_poly_wave_synth.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_wave_synth_if.sv
// Bundle between the keyboard/control side and poly_wave_synth.
//   master: drives tick, per-voice phase increments and gates, wave/envelope/mix
//           controls; observes audio_out, audio_valid, busy, active, overrun.
//   slave : the synthesizer side of the same signals.
interface poly_wave_synth_if #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned VOL_W   = 8,
    parameter int unsigned OUT_W   = 16
);
    logic                        sample_tick;
    logic [VOICES*PHASE_W-1:0]   phase_inc;
    logic [VOICES-1:0]           gate;
    logic [1:0]                  wave_sel;
    logic [VOL_W-1:0]            attack_rate;
    logic [VOL_W-1:0]            release_rate;
    logic [2:0]                  master_shift;
    logic signed [OUT_W-1:0]     audio_out;
    logic                        audio_valid;
    logic                        busy;
    logic [VOICES-1:0]           active;
    logic                        overrun;

    modport master (
        output sample_tick, phase_inc, gate, wave_sel,
               attack_rate, release_rate, master_shift,
        input  audio_out, audio_valid, busy, active, overrun
    );

    modport slave (
        input  sample_tick, phase_inc, gate, wave_sel,
               attack_rate, release_rate, master_shift,
        output audio_out, audio_valid, busy, active, overrun
    );
endinterface

// File: rtl/poly_wave_synth.sv
// Time-multiplexed polyphonic synthesizer: one voice per clock after each
// sample_tick, each voice with its own phase accumulator and attack/release
// envelope, mixed into a saturated signed sample.
//   clk      : audio clock
//   reset_n  : synchronous, active-low reset
//   bus      : slave side of poly_wave_synth_if (controls in, sample/status out)
module poly_wave_synth #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned VOL_W   = 8,
    parameter int unsigned OUT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    poly_wave_synth_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(VOICES);
    localparam int unsigned ACC_W  = 9 + VOL_W + $clog2(VOICES);
    localparam int unsigned PROD_W = 8 + VOL_W + 1;

    localparam logic [VOL_W-1:0]        ENV_MAX = '1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [IDX_W-1:0]         idx;
    logic [1:0]               wave_q;
    logic signed [ACC_W-1:0]  acc;
    logic [PHASE_W-1:0]       phase [VOICES];
    logic [VOL_W-1:0]         env   [VOICES];

    logic [PHASE_W-1:0]       inc_c;
    logic [PHASE_W-1:0]       phase_c;
    logic [VOL_W:0]           env_up_c;
    logic [VOL_W-1:0]         env_c;
    logic [7:0]               p_c;
    logic [6:0]               tri_c;
    logic signed [7:0]        smp_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  y_c;
    logic signed [OUT_W-1:0]  out_c;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.sample_tick) state_nx = S_RUN;
            S_RUN:   if (idx == IDX_W'(VOICES - 1)) state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Current voice step; gate and increment are taken live in this cycle
    always_comb begin
        inc_c    = bus.phase_inc[idx*PHASE_W +: PHASE_W];
        phase_c  = phase[idx] + inc_c;
        env_up_c = '0;
        env_c    = env[idx];
        if (bus.gate[idx]) begin
            // Extra carry bit detects overflow for the saturating attack
            env_up_c = {1'b0, env[idx]} + {1'b0, bus.attack_rate};
            env_c    = env_up_c[VOL_W] ? ENV_MAX : env_up_c[VOL_W-1:0];
        end else begin
            env_c = (env[idx] > bus.release_rate) ? (env[idx] - bus.release_rate) : '0;
        end

        p_c   = phase_c[PHASE_W-1 -: 8];
        tri_c = p_c[7] ? ~p_c[6:0] : p_c[6:0];
        smp_c = '0;
        case (wave_q)
            2'd0:    smp_c = p_c[7] ? 8'sh80 : 8'sh7F;
            // p - 128 and 2t - 128 reduce to flipping the top bit
            2'd1:    smp_c = $signed({~p_c[7], p_c[6:0]});
            2'd2:    smp_c = $signed({~tri_c[6], tri_c[5:0], 1'b0});
            default: smp_c = '0;
        endcase
        prod_c = smp_c * $signed({1'b0, env_c});
    end

    // Output scaling and saturation
    always_comb begin
        y_c = acc >>> bus.master_shift;
        if (y_c > SAT_MAX) begin
            out_c = OUT_W'(SAT_MAX);
        end else if (y_c < SAT_MIN) begin
            out_c = OUT_W'(SAT_MIN);
        end else begin
            out_c = OUT_W'(y_c);
        end
    end

    // State, voice memory and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            idx             <= '0;
            wave_q          <= '0;
            acc             <= '0;
            bus.busy        <= 1'b0;
            bus.audio_out   <= '0;
            bus.audio_valid <= 1'b0;
            bus.active      <= '0;
            bus.overrun     <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
                env[i]   <= '0;
            end
        end else begin
            state           <= state_nx;
            bus.busy        <= (state_nx != S_IDLE);
            bus.audio_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.sample_tick) begin
                        wave_q <= bus.wave_sel;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                S_RUN: begin
                    phase[idx]      <= phase_c;
                    env[idx]        <= env_c;
                    bus.active[idx] <= (env_c != '0);
                    acc             <= acc + ACC_W'(prod_c);
                    idx             <= idx + 1'b1;
                end
                S_OUT: begin
                    bus.audio_out   <= out_c;
                    bus.audio_valid <= 1'b1;
                end
                default: ;
            endcase
            // A tick during a frame is dropped but remembered until reset
            if (bus.sample_tick && (state != S_IDLE)) begin
                bus.overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_poly_wave_synth.sv
// Scoreboard bench for poly_wave_synth: a frame model predicts each sample
// when its tick is driven, and the monitor compares on every audio_valid.
module tb_poly_wave_synth;

    localparam int unsigned V   = 8;
    localparam int unsigned PW  = 24;
    localparam int unsigned VW  = 8;
    localparam int unsigned OW  = 16;
    localparam int          ENV_TOP = (1 << VW) - 1;

    typedef struct {
        int           sample;
        logic [V-1:0] act;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    int   n_valid;
    int   m_phase [V];
    int   m_env   [V];
    exp_t sb [$];
    exp_t mon_e;

    poly_wave_synth_if #(.VOICES(V), .PHASE_W(PW), .VOL_W(VW), .OUT_W(OW)) bus ();

    poly_wave_synth #(.VOICES(V), .PHASE_W(PW), .VOL_W(VW), .OUT_W(OW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model_frame();
        exp_t   e;
        longint acc;
        longint y;
        int     p;
        int     t;
        int     s;
        acc   = 0;
        e.act = '0;
        for (int i = 0; i < V; i++) begin
            m_phase[i] = (m_phase[i] + int'(bus.phase_inc[i*PW +: PW])) % (1 << PW);
            if (bus.gate[i]) begin
                m_env[i] = m_env[i] + int'(bus.attack_rate);
                if (m_env[i] > ENV_TOP) m_env[i] = ENV_TOP;
            end else begin
                m_env[i] = m_env[i] - int'(bus.release_rate);
                if (m_env[i] < 0) m_env[i] = 0;
            end
            p = m_phase[i] / (1 << (PW - 8));
            case (bus.wave_sel)
                2'd0:    s = (p >= 128) ? -128 : 127;
                2'd1:    s = p - 128;
                2'd2:    begin t = (p >= 128) ? (255 - p) : p; s = 2 * t - 128; end
                default: s = 0;
            endcase
            acc += longint'(s * m_env[i]);
            e.act[i] = (m_env[i] != 0);
        end
        y = acc >>> bus.master_shift;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        e.sample = int'(y);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_phase[i] = 0;
            m_env[i]   = 0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic tick();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        sb.push_back(model_frame());
        @(negedge clk);
        bus.sample_tick = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) break;
        end
        if (k == 40) begin
            check("frame_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_frame();
        tick();
        wait_done();
    endtask

    task automatic set_inc(input int v, input logic [PW-1:0] val);
        bus.phase_inc[v*PW +: PW] = val;
    endtask

    // Scoreboard monitor, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (bus.audio_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("audio_out", longint'($signed(bus.audio_out)), mon_e.sample);
                check("active", longint'(bus.active), longint'(mon_e.act));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int n0;
        n_vec   = 0;
        n_err   = 0;
        n_valid = 0;
        reset_n = 1'b0;
        bus.sample_tick  = 1'b1;
        bus.phase_inc    = '0;
        bus.gate         = '0;
        bus.wave_sel     = 2'd0;
        bus.attack_rate  = '0;
        bus.release_rate = '0;
        bus.master_shift = 3'd0;
        model_reset();

        // Reset held two cycles with tick asserted
        repeat (2) @(negedge clk);
        bus.sample_tick = 1'b0;
        check("rst_audio_out", longint'($signed(bus.audio_out)), 0);
        check("rst_valid", bus.audio_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_active", longint'(bus.active), 0);
        check("rst_overrun", bus.overrun, 0);
        reset_n = 1'b1;

        // Single square voice, with tick-to-valid latency
        set_inc(0, 24'h800000);
        bus.gate        = 8'h01;
        bus.attack_rate = 8'd255;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        sb.push_back(model_frame());
        @(posedge clk);
        #1 bus.sample_tick = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            lat++;
            if (bus.audio_valid) break;
        end
        check("latency", lat, 9);
        wait_done();
        check("square_first", longint'($signed(bus.audio_out)), -32640);
        run_frame();
        check("square_second", longint'($signed(bus.audio_out)), 32385);
        run_frame();
        check("square_active", longint'(bus.active), 1);

        // All voices identical: saturation, then attenuated by 3
        do_reset();
        for (int i = 0; i < V; i++) set_inc(i, 24'h800000);
        bus.gate = 8'hFF;
        run_frame();
        check("sat_low", longint'($signed(bus.audio_out)), -32768);
        do_reset();
        bus.master_shift = 3'd3;
        run_frame();
        check("shift3", longint'($signed(bus.audio_out)), -32640);
        run_frame();

        // Attack of zero freezes the envelope, then release to silence
        do_reset();
        bus.master_shift = 3'd0;
        bus.phase_inc    = '0;
        set_inc(0, 24'h800000);
        bus.gate        = 8'h01;
        bus.attack_rate = 8'd255;
        run_frame();
        bus.attack_rate = 8'd0;
        run_frame();
        check("attack0_hold", longint'($signed(bus.audio_out)), 32385);
        bus.gate         = 8'h00;
        bus.release_rate = 8'd64;
        repeat (3) run_frame();
        check("release_active", longint'(bus.active), 1);
        run_frame();
        check("release_done", longint'(bus.active), 0);
        run_frame();
        check("release_silent", longint'($signed(bus.audio_out)), 0);

        // Saw, triangle and silent waves over mixed increments and gates
        do_reset();
        for (int i = 0; i < V; i++) set_inc(i, PW'(24'h051EB8 * (i + 1)));
        bus.gate         = 8'h5B;
        bus.attack_rate  = 8'd40;
        bus.release_rate = 8'd7;
        bus.wave_sel     = 2'd1;
        repeat (3) run_frame();
        bus.wave_sel = 2'd2;
        bus.gate     = 8'hA7;
        repeat (3) run_frame();
        bus.wave_sel     = 2'd3;
        bus.master_shift = 3'd2;
        run_frame();
        bus.wave_sel = 2'd2;
        repeat (2) run_frame();

        // Overrun: second tick three cycles into the frame
        bus.master_shift = 3'd0;
        n0 = n_valid;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        sb.push_back(model_frame());
        @(negedge clk);
        bus.sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        check("overrun_pulses", n_valid - n0, 1);
        check("overrun_set", bus.overrun, 1);
        run_frame();
        check("overrun_sticky", bus.overrun, 1);
        do_reset();
        check("overrun_cleared", bus.overrun, 0);

        // Reset during the fourth voice cycle abandons the frame
        bus.phase_inc   = '0;
        set_inc(0, 24'h300000);
        bus.gate        = 8'h01;
        bus.attack_rate = 8'd100;
        bus.wave_sel    = 2'd1;
        run_frame();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        reset_n = 1'b1;
        model_reset();
        n0 = n_valid;
        repeat (12) @(negedge clk);
        check("abort_no_valid", n_valid - n0, 0);
        run_frame();
        check("abort_fresh", longint'($signed(bus.audio_out)), -8000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
